// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default address width,
// pointer width and the binary-to-Gray helper used by both clock domains.
package fifo_pkg;

  localparam int ADDR_W = 3;
  localparam int PTR_W  = ADDR_W + 1;

  // Works on a 32-bit container so any pointer width can cast the result down.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_decoder.sv
// Gray-to-binary decoder, parameterised in width (default matches the
// FIFO pointer width).
module gray_decoder #(
  parameter int W = fifo_pkg::PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    bin[W-1] = gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/ptr_sync_2ff.sv
// Two-stage flip-flop synchroniser for a Gray-coded pointer crossing into
// the local clock domain.
module ptr_sync_2ff #(
  parameter int W = fifo_pkg::PTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] rq1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1 <= '0;
      q   <= '0;
    end else begin
      rq1 <= d;
      q   <= rq1;
    end
  end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer and registered full-flag controller of the async FIFO.
// Optional sticky overflow flag is built when FIFO_OVERFLOW_EN is defined.
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              write_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   read_ptr_gray,
  output logic [ADDR_W:0]   write_ptr_gray,
  output logic [ADDR_W-1:0] write_addr,
  output logic              mem_we,
  output logic              full
`ifdef FIFO_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] write_ptr;
  logic [PW-1:0] write_ptr_next;
  logic [PW-1:0] write_gray_next;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rptr_bin;
  logic          accept;
  logic          full_next;

  ptr_sync_2ff #(.W(PW)) u_rptr_sync (
    .clk   (write_clk),
    .rst_n (rst_n),
    .d     (read_ptr_gray),
    .q     (rq2)
  );

  gray_decoder #(.W(PW)) u_rptr_dec (
    .gray (rq2),
    .bin  (rptr_bin)
  );

  assign accept          = wr_en & ~full;
  assign mem_we          = accept;
  assign write_addr      = write_ptr[ADDR_W-1:0];
  assign write_ptr_next  = write_ptr + {{ADDR_W{1'b0}}, accept};
  assign write_gray_next = PW'(bin2gray(32'(write_ptr_next)));

  // Full looks ahead at the post-write pointer so the last free slot flags full on its own edge.
  assign full_next = (write_ptr_next[ADDR_W] != rptr_bin[ADDR_W]) &&
                     (write_ptr_next[ADDR_W-1:0] == rptr_bin[ADDR_W-1:0]);

  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      write_ptr      <= '0;
      write_ptr_gray <= '0;
      full           <= 1'b0;
    end else begin
      write_ptr      <= write_ptr_next;
      write_ptr_gray <= write_gray_next;
      full           <= full_next;
    end
  end

`ifdef FIFO_OVERFLOW_EN
  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl: occupancy-based reference model
// compared every cycle, plus directed checks with hand-computed values.
module tb_fifo_write_ctrl;

  localparam int ADDR_W = 3;

  logic              write_clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W:0]   read_ptr_gray;
  logic [ADDR_W:0]   write_ptr_gray;
  logic [ADDR_W-1:0] write_addr;
  logic              mem_we;
  logic              full;
`ifdef FIFO_OVERFLOW_EN
  logic              overflow;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  fifo_write_ctrl #(.ADDR_W(ADDR_W)) dut (
    .write_clk      (write_clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .read_ptr_gray  (read_ptr_gray),
    .write_ptr_gray (write_ptr_gray),
    .write_addr     (write_addr),
    .mem_we         (mem_we),
    .full           (full)
`ifdef FIFO_OVERFLOW_EN
    ,
    .overflow       (overflow)
`endif
  );

  always #5 write_clk = ~write_clk;

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int bin_of(input int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
  endfunction

  // Reference model: counts accepted writes and sees the read pointer two edges late.
  int m_wcount = 0;
  int m_hist1  = 0;
  int m_hist2  = 0;
  bit m_full   = 1'b0;
  bit m_ovf    = 1'b0;

  always @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wcount = 0;
      m_hist1  = 0;
      m_hist2  = 0;
      m_full   = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      int rb;
      rb = bin_of(m_hist2);
      if (wr_en && m_full) m_ovf = 1'b1;
      if (wr_en && !m_full) m_wcount++;
      m_full  = (((m_wcount - rb) % 16 + 16) % 16) == 8;
      m_hist2 = m_hist1;
      m_hist1 = int'(read_ptr_gray);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge write_clk) begin
    checkOutput("model write_addr", int'(write_addr), m_wcount % 8);
    checkOutput("model write_ptr_gray", int'(write_ptr_gray), gray_of(m_wcount % 16));
    checkOutput("model mem_we", int'(mem_we), int'(wr_en && !m_full));
    checkOutput("model full", int'(full), int'(m_full));
`ifdef FIFO_OVERFLOW_EN
    checkOutput("model overflow", int'(overflow), int'(m_ovf));
`endif
  end

  // Drive inputs just after an edge, then let one write_clk edge pass.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W:0] rg);
    wr_en         = wr;
    read_ptr_gray = rg;
    @(posedge write_clk);
    #1;
  endtask

  initial begin
    int issued;
    logic [ADDR_W:0] prev_gray;

    rst_n         = 1'b0;
    wr_en         = 1'b1;
    read_ptr_gray = '0;
    repeat (3) begin
      @(posedge write_clk);
      #1;
    end
    checkOutput("reset full", int'(full), 0);
    checkOutput("reset write_addr", int'(write_addr), 0);
    checkOutput("reset write_ptr_gray", int'(write_ptr_gray), 0);
    checkOutput("reset mem_we", int'(mem_we), 1);
    wr_en = 1'b0;
    rst_n = 1'b1;
    @(posedge write_clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      #1;
      checkOutput("fill write_addr", int'(write_addr), i);
      checkOutput("fill full before edge", int'(full), 0);
      applyStimulus(1'b1, 4'b0000);
    end
    checkOutput("fill full", int'(full), 1);
    checkOutput("fill write_ptr_gray", int'(write_ptr_gray), 4'b1100);
    checkOutput("fill write_addr wrapped", int'(write_addr), 0);

    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("overflow mem_we", int'(mem_we), 0);
    checkOutput("overflow gray held", int'(write_ptr_gray), 4'b1100);
`ifdef FIFO_OVERFLOW_EN
    checkOutput("overflow set", int'(overflow), 1);
`endif
    applyStimulus(1'b0, 4'b0000);
`ifdef FIFO_OVERFLOW_EN
    checkOutput("overflow sticky", int'(overflow), 1);
`endif

    applyStimulus(1'b0, 4'b0001);
    checkOutput("release edge1 full", int'(full), 1);
    applyStimulus(1'b0, 4'b0001);
    checkOutput("release edge2 full", int'(full), 1);
    applyStimulus(1'b0, 4'b0001);
    checkOutput("release edge3 full", int'(full), 0);
    wr_en = 1'b1;
    #1;
    checkOutput("release next addr", int'(write_addr), 0);
    checkOutput("release next mem_we", int'(mem_we), 1);
    applyStimulus(1'b1, 4'b0001);
    checkOutput("release refill full", int'(full), 1);
    checkOutput("release gray of 9", int'(write_ptr_gray), 4'b1101);

    // Move the reader to two behind the writer (count 9) and let it settle.
    issued = 9;
    repeat (3) applyStimulus(1'b0, 4'(gray_of(issued - 2)));
    checkOutput("wrap start full", int'(full), 0);
    for (int i = 0; i < 20; i++) begin
      prev_gray = write_ptr_gray;
      applyStimulus(1'b1, 4'(gray_of((issued - 2) % 16)));
      issued++;
      checkOutput("wrap one-bit gray step", $countones(prev_gray ^ write_ptr_gray), 1);
      checkOutput("wrap full low", int'(full), 0);
    end
    checkOutput("wrap final addr", int'(write_addr), 5);
    checkOutput("wrap final gray", int'(write_ptr_gray), 4'b1011);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'(gray_of((issued - 2) % 16)));
      issued++;
    end
    wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset full", int'(full), 0);
    checkOutput("midreset write_addr", int'(write_addr), 0);
    checkOutput("midreset write_ptr_gray", int'(write_ptr_gray), 0);
    checkOutput("midreset mem_we", int'(mem_we), 0);
`ifdef FIFO_OVERFLOW_EN
    checkOutput("midreset overflow", int'(overflow), 0);
`endif
    read_ptr_gray = '0;
    @(posedge write_clk);
    #3;
    rst_n = 1'b1;
    @(posedge write_clk);
    #1;
    wr_en = 1'b1;
    #1;
    checkOutput("after reset addr", int'(write_addr), 0);
    checkOutput("after reset mem_we", int'(mem_we), 1);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("after reset next addr", int'(write_addr), 1);
    wr_en = 1'b0;
    repeat (2) @(posedge write_clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
